// File: rtl/day6_pkg.sv
// Shared day-6 definitions: ASCII codes, op encodings and record geometry
// used by the column parser and the part-2 compactor.
package day6_pkg;
  localparam int DATA_WIDTH      = 16;
  localparam int DIGITS_PER_PROB = 4;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_MUL = 8'h2A;
  localparam logic [7:0] ASCII_ADD = 8'h2B;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Encoding stored in the operator row RAM; 00 means no operator here.
  typedef enum logic [1:0] {
    ROP_NONE = 2'b00,
    ROP_MUL  = 2'b01,
    ROP_ADD  = 2'b10
  } row_op_e;

  typedef enum logic [2:0] {
    S_LOAD, S_BYTES, S_SCAN, S_FLUSH, S_DONE
  } state_e;
endpackage

// File: rtl/trash_column_parser_if.sv
// Text word stream in, problem records and status out.
interface trash_column_parser_if #(
  parameter int PROB_W = 10
);
  import day6_pkg::*;

  logic [31:0]           data_in;
  logic                  valid_in;
  logic                  ready;
  logic                  wr_en;
  logic [PROB_W-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0] wr_line1;
  logic [DATA_WIDTH-1:0] wr_line2;
  logic [DATA_WIDTH-1:0] wr_line3;
  logic [DATA_WIDTH-1:0] wr_line4;
  logic                  wr_op;
  logic [PROB_W:0]       num_problems;
  logic                  finished;
  logic                  err;

  modport master (
    output data_in, valid_in,
    input  ready, wr_en, wr_addr, wr_line1, wr_line2, wr_line3, wr_line4,
           wr_op, num_problems, finished, err
  );

  modport slave (
    input  data_in, valid_in,
    output ready, wr_en, wr_addr, wr_line1, wr_line2, wr_line3, wr_line4,
           wr_op, num_problems, finished, err
  );
endinterface

// File: rtl/trash_row_ram.sv
// Single-port row store, write-first-ignored, registered read (1-cycle latency).
module trash_row_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/trash_column_parser.sv
// Rebuilds the four digit rows and the operator row from ASCII text, then
// scans column by column and emits one column-packed record per problem.
module trash_column_parser
  import day6_pkg::*;
#(
  parameter int MAX_COLS     = 4096,
  parameter int COL_W        = 12,
  parameter int MAX_PROBLEMS = 1000,
  parameter int PROB_W       = 10
) (
  input logic                  clk,
  input logic                  rst,
  trash_column_parser_if.slave bus
);
  localparam int NROWS = 5;
  localparam int OPROW = 4;

  state_e         state, state_nx;
  logic [31:0]    word;
  logic [1:0]     lane;
  logic [2:0]     row;
  logic [COL_W:0] col, scol, ev_col, max_len;
  logic [COL_W:0] lens [NROWS];
  logic           ev_vld, open;
  logic [2:0]     k;
  logic           cur_op;
  logic [DIGITS_PER_PROB-1:0][DATA_WIDTH-1:0] cur_lines;

  logic [7:0]       cur_byte;
  logic             is_lf, is_skip, is_sp, is_dig, char_bad, put, in_range, issue;
  logic [3:0]       dig_val;
  logic [1:0]       op_val;
  logic [NROWS-1:0] ram_we;
  logic [COL_W-1:0] ram_addr;
  logic [3:0]       rd_dig [4];
  logic [1:0]       rd_op;
  logic [3:0][3:0]  dgt;
  logic [1:0]       opc;
  logic             blank, emit;

  for (genvar r = 0; r < 4; r++) begin : g_dig
    trash_row_ram #(.WIDTH(4), .DEPTH(MAX_COLS), .AW(COL_W)) u_ram (
      .clk(clk), .we(ram_we[r]), .addr(ram_addr), .wdata(dig_val), .rdata(rd_dig[r])
    );
  end

  trash_row_ram #(.WIDTH(2), .DEPTH(MAX_COLS), .AW(COL_W)) u_op_ram (
    .clk(clk), .we(ram_we[OPROW]), .addr(ram_addr), .wdata(op_val), .rdata(rd_op)
  );

  // Byte decode for the load phase
  always_comb begin
    cur_byte = word[{lane, 3'b000} +: 8];
    is_lf    = cur_byte == ASCII_LF;
    is_skip  = (cur_byte == 8'h00) || (cur_byte == ASCII_CR);
    is_sp    = cur_byte == ASCII_SP;
    is_dig   = (cur_byte >= ASCII_0) && (cur_byte <= ASCII_9);
    dig_val  = (is_dig && cur_byte != ASCII_0) ? cur_byte[3:0] : 4'd0;
    op_val   = (cur_byte == ASCII_MUL) ? ROP_MUL :
               (cur_byte == ASCII_ADD) ? ROP_ADD : ROP_NONE;
    char_bad = (row == 3'(OPROW)) ? (op_val == ROP_NONE && !is_sp)
                                  : !(is_sp || (is_dig && cur_byte != ASCII_0));
    put      = (state == S_BYTES) && !is_lf && !is_skip;
    in_range = col < (COL_W+1)'(MAX_COLS);
    ram_we   = '0;
    if (put && in_range) ram_we[row] = 1'b1;
  end

  // Scan side: a column is evaluated the cycle after its address is issued
  always_comb begin
    max_len = '0;
    for (int i = 0; i < NROWS; i++)
      if (lens[i] > max_len) max_len = lens[i];
    issue    = (state == S_SCAN) && (scol < max_len);
    ram_addr = (state == S_SCAN) ? scol[COL_W-1:0] : col[COL_W-1:0];
    for (int r = 0; r < 4; r++)
      dgt[r] = (ev_col < lens[r]) ? rd_dig[r] : 4'd0;
    opc   = (ev_col < lens[OPROW]) ? rd_op : ROP_NONE;
    blank = dgt == '0;
    emit  = open && ((ev_vld && opc != ROP_NONE) || state == S_FLUSH);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (bus.valid_in) state_nx = S_BYTES;
      S_BYTES: if (is_lf && row == 3'(OPROW)) state_nx = S_SCAN;
               else if (lane == 2'd3)        state_nx = S_LOAD;
      S_SCAN:  if (!issue && !ev_vld) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_LOAD;
    else     state <= state_nx;

  assign bus.ready = state == S_LOAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0; lane <= '0; row <= '0; col <= '0; scol <= '0;
      for (int i = 0; i < NROWS; i++) lens[i] <= '0;
      ev_vld <= 1'b0; ev_col <= '0; open <= 1'b0; k <= '0;
      cur_op <= OP_MUL; cur_lines <= '0;
      bus.wr_en <= 1'b0; bus.wr_addr <= '0; bus.wr_op <= 1'b0;
      bus.wr_line1 <= '0; bus.wr_line2 <= '0; bus.wr_line3 <= '0; bus.wr_line4 <= '0;
      bus.num_problems <= '0; bus.finished <= 1'b0; bus.err <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        S_LOAD: if (bus.valid_in) begin
          word <= bus.data_in;
          lane <= '0;
        end
        S_BYTES: begin
          lane <= lane + 2'd1;
          if (is_lf) begin
            lens[row] <= col;
            col       <= '0;
            row       <= row + 3'd1;
          end else if (put && in_range) begin
            col <= col + 1'b1;
          end
          if (put && (char_bad || !in_range)) bus.err <= 1'b1;
        end
        default: ;
      endcase

      ev_vld <= issue;
      ev_col <= scol;
      if (issue) scol <= scol + 1'b1;

      if (ev_vld) begin
        if (opc != ROP_NONE) begin
          // Operator column opens a problem and is its first digit column
          open   <= 1'b1;
          k      <= 3'd1;
          cur_op <= (opc == ROP_ADD) ? OP_ADD : OP_MUL;
          for (int r = 0; r < 4; r++) cur_lines[r] <= {{(DATA_WIDTH-4){1'b0}}, dgt[r]};
        end else if (open) begin
          if (k < 3'(DIGITS_PER_PROB)) begin
            for (int r = 0; r < 4; r++) cur_lines[r][{k[1:0], 2'b00} +: 4] <= dgt[r];
            k <= k + 3'd1;
          end else if (!blank) begin
            bus.err <= 1'b1;
          end
        end else if (!blank) begin
          bus.err <= 1'b1;
        end
      end

      if (emit) begin
        if (bus.num_problems == (PROB_W+1)'(MAX_PROBLEMS)) begin
          bus.err <= 1'b1;
        end else begin
          bus.wr_en        <= 1'b1;
          bus.wr_addr      <= bus.num_problems[PROB_W-1:0];
          bus.wr_line1     <= cur_lines[0];
          bus.wr_line2     <= cur_lines[1];
          bus.wr_line3     <= cur_lines[2];
          bus.wr_line4     <= cur_lines[3];
          bus.wr_op        <= cur_op;
          bus.num_problems <= bus.num_problems + 1'b1;
        end
      end

      if (state == S_FLUSH) begin
        open         <= 1'b0;
        bus.finished <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trash_column_parser.sv
// Bench for trash_column_parser: directed texts plus random puzzles checked
// against a string-level model of the column/problem rules.
module tb_trash_column_parser;
  import day6_pkg::*;

  localparam int MAX_COLS = 4096, COL_W = 12, MAX_PROBLEMS = 1000, PROB_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trash_column_parser_if #(.PROB_W(PROB_W)) bus();

  trash_column_parser #(
    .MAX_COLS(MAX_COLS), .COL_W(COL_W), .MAX_PROBLEMS(MAX_PROBLEMS), .PROB_W(PROB_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic [PROB_W-1:0] addr;
    logic [15:0]       l1, l2, l3, l4;
    logic              op;
  } rec_t;

  rec_t got[$];
  rec_t exp_q[$];
  logic exp_err;
  int   vectors = 0;
  int   errors  = 0;

  localparam string TXT1 = "12 3\n34 4\n5  5\n6  6\n*  +\n";

  always @(negedge clk) begin
    rec_t r;
    if (!rst && bus.wr_en) begin
      r.addr = bus.wr_addr; r.l1 = bus.wr_line1; r.l2 = bus.wr_line2;
      r.l3 = bus.wr_line3;  r.l4 = bus.wr_line4; r.op = bus.wr_op;
      got.push_back(r);
    end
  end

  function automatic rec_t mkrec(input int a, input logic [15:0] l1, l2, l3, l4, input logic op);
    rec_t r;
    r.addr = PROB_W'(a); r.l1 = l1; r.l2 = l2; r.l3 = l3; r.l4 = l4; r.op = op;
    return r;
  endfunction

  // Reference: split text into rows, walk columns, group into problems
  function automatic void model(input string txt);
    string rs[5];
    int r = 0, ncol = 0, k = 0, opk;
    bit open = 0, blank;
    logic [7:0] ch;
    int nib[4];
    logic [15:0] ln[4];
    logic cop = 0;
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < txt.len() && r < 5; i++) begin
      ch = txt[i];
      if (ch == 8'h00 || ch == ASCII_CR) continue;
      if (ch == ASCII_LF) begin r++; continue; end
      rs[r] = {rs[r], $sformatf("%c", ch)};
    end
    for (int j = 0; j < 5; j++) if (rs[j].len() > ncol) ncol = rs[j].len();
    for (int c = 0; c < ncol; c++) begin
      blank = 1;
      for (int j = 0; j < 4; j++) begin
        ch = (c < rs[j].len()) ? rs[j][c] : ASCII_SP;
        if (ch > ASCII_0 && ch <= ASCII_9) nib[j] = int'(ch) - int'(ASCII_0);
        else begin nib[j] = 0; if (ch != ASCII_SP) exp_err = 1; end
        if (nib[j] != 0) blank = 0;
      end
      ch  = (c < rs[4].len()) ? rs[4][c] : ASCII_SP;
      opk = (ch == ASCII_MUL) ? 1 : (ch == ASCII_ADD) ? 2 : 0;
      if (opk == 0 && ch != ASCII_SP) exp_err = 1;
      if (opk != 0) begin
        if (open) exp_q.push_back(mkrec(exp_q.size(), ln[0], ln[1], ln[2], ln[3], cop));
        open = 1; k = 0; cop = (opk == 2);
        for (int j = 0; j < 4; j++) ln[j] = '0;
      end
      if (open) begin
        if (k < 4) begin
          for (int j = 0; j < 4; j++) ln[j][4*k +: 4] = 4'(nib[j]);
          k++;
        end else if (!blank) exp_err = 1;
      end else if (!blank) exp_err = 1;
    end
    if (open) exp_q.push_back(mkrec(exp_q.size(), ln[0], ln[1], ln[2], ln[3], cop));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
  endtask

  // Drives up to maxw words (all if maxw<0); optionally checks ready drops after each accept
  task automatic send_text(input string txt, input int max_gap, input bit chk_ready, input int maxw);
    int n = (txt.len() + 3) / 4;
    int t;
    logic [31:0] d;
    if (maxw >= 0 && maxw < n) n = maxw;
    for (int w = 0; w < n; w++) begin
      d = '0;
      for (int b = 0; b < 4; b++)
        if (4*w + b < txt.len()) d[8*b +: 8] = txt[4*w + b];
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      bus.data_in  = d;
      bus.valid_in = 1'b1;
      t = 0;
      while (!bus.ready && t < 100) begin @(negedge clk); t++; end
      if (!bus.ready) begin
        vectors++; errors++;
        $display("FAIL ready_timeout word %0d: ready=%b required 1", w, bus.ready);
        bus.valid_in = 1'b0;
        return;
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (chk_ready) begin
        vectors++;
        if (bus.ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_accept word %0d: ready=%b required 0", w, bus.ready);
        end
      end
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.finished && t < 20000) begin @(negedge clk); t++; end
    vectors++;
    if (bus.finished !== 1'b1) begin
      errors++;
      $display("FAIL finished_timeout: finished=%b required 1", bus.finished);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: %b required 1", bus.ready); end
    vectors++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: %b required 0", bus.wr_en); end
    vectors++; if (bus.wr_addr !== '0) begin errors++; $display("FAIL rst_wr_addr: %0d required 0", bus.wr_addr); end
    vectors++;
    if ({bus.wr_line1, bus.wr_line2, bus.wr_line3, bus.wr_line4, bus.wr_op} !== '0) begin
      errors++; $display("FAIL rst_lines: %h %h %h %h op %b required 0", bus.wr_line1, bus.wr_line2, bus.wr_line3, bus.wr_line4, bus.wr_op);
    end
    vectors++; if (bus.num_problems !== '0) begin errors++; $display("FAIL rst_num: %0d required 0", bus.num_problems); end
    vectors++; if (bus.finished !== 1'b0) begin errors++; $display("FAIL rst_finished: %b required 0", bus.finished); end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: %b required 0", bus.err); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    rec_t e[2];
    e[0] = mkrec(0, 16'h0021, 16'h0043, 16'h0005, 16'h0006, OP_MUL);
    e[1] = mkrec(1, 16'h0003, 16'h0004, 16'h0005, 16'h0006, OP_ADD);
    do_reset();
    send_text(TXT1, 0, 0, -1);
    wait_done();
    vectors++; if (got.size() != 2) begin errors++; $display("FAIL basic_count: %0d required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL basic_rec%0d: %h required %h", i, got[i], e[i]); end
    end
    vectors++; if (bus.num_problems !== 11'd2) begin errors++; $display("FAIL basic_num: %0d required 2", bus.num_problems); end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: %b required 0", bus.err); end
    vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: %b required 0", bus.ready); end
  endtask

  task automatic test_crlf_gaps();
    string txt = "12 3\r\n34 4\r\n5  5\r\n6  6\r\n*  +\r\n";
    rec_t e[2];
    e[0] = mkrec(0, 16'h0021, 16'h0043, 16'h0005, 16'h0006, OP_MUL);
    e[1] = mkrec(1, 16'h0003, 16'h0004, 16'h0005, 16'h0006, OP_ADD);
    do_reset();
    send_text(txt, 1, 1, -1);
    wait_done();
    vectors++; if (got.size() != 2) begin errors++; $display("FAIL crlf_count: %0d required 2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL crlf_rec%0d: %h required %h", i, got[i], e[i]); end
    end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL crlf_err: %b required 0", bus.err); end
  endtask

  task automatic test_short_row();
    do_reset();
    send_text("12\n34 4\n5  5\n6  6\n*  +\n", 0, 0, -1);
    wait_done();
    vectors++; if (got.size() != 2) begin errors++; $display("FAIL short_count: %0d required 2", got.size()); end
    vectors++;
    if (got.size() > 1 && got[1] !== mkrec(1, 16'h0000, 16'h0004, 16'h0005, 16'h0006, OP_ADD)) begin
      errors++; $display("FAIL short_rec1: %h required line1 0000", got[1]);
    end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL short_err: %b required 0", bus.err); end
  endtask

  task automatic test_wide_problem();
    do_reset();
    send_text("12345\n12345\n12345\n12345\n*    \n", 0, 0, -1);
    wait_done();
    vectors++; if (got.size() != 1) begin errors++; $display("FAIL wide_count: %0d required 1", got.size()); end
    vectors++;
    if (got.size() > 0 && got[0].l1 !== 16'h4321) begin errors++; $display("FAIL wide_line1: %h required 4321", got[0].l1); end
    vectors++; if (bus.err !== 1'b1) begin errors++; $display("FAIL wide_err: %b required 1", bus.err); end
  endtask

  task automatic test_bad_char();
    do_reset();
    send_text("1x 3\n34 4\n5  5\n6  6\n*  +\n", 0, 0, -1);
    wait_done();
    vectors++; if (bus.err !== 1'b1) begin errors++; $display("FAIL badchar_err: %b required 1", bus.err); end
    vectors++;
    if (got.size() > 0 && got[0].l1 !== 16'h0001) begin errors++; $display("FAIL badchar_line1: %h required 0001", got[0].l1); end
    vectors++; if (bus.num_problems !== 11'd2) begin errors++; $display("FAIL badchar_num: %0d required 2", bus.num_problems); end
  endtask

  task automatic test_empty();
    do_reset();
    send_text("\n\n\n\n\n", 0, 0, -1);
    wait_done();
    vectors++; if (got.size() != 0) begin errors++; $display("FAIL empty_strobes: %0d required 0", got.size()); end
    vectors++; if (bus.num_problems !== '0) begin errors++; $display("FAIL empty_num: %0d required 0", bus.num_problems); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_text(TXT1, 0, 0, 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    vectors++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: %b required 1", bus.ready); end
    send_text(TXT1, 0, 0, -1);
    wait_done();
    vectors++; if (got.size() != 2) begin errors++; $display("FAIL midrst_count: %0d required 2", got.size()); end
    vectors++;
    if (got.size() > 0 && got[0] !== mkrec(0, 16'h0021, 16'h0043, 16'h0005, 16'h0006, OP_MUL)) begin
      errors++; $display("FAIL midrst_rec0: %h", got[0]);
    end
    vectors++;
    if (got.size() > 1 && got[1] !== mkrec(1, 16'h0003, 16'h0004, 16'h0005, 16'h0006, OP_ADD)) begin
      errors++; $display("FAIL midrst_rec1: %h", got[1]);
    end
    vectors++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err: %b required 0", bus.err); end
  endtask

  function automatic string gen_puzzle(input bit crlf);
    string rs[5];
    string txt = "";
    int np = $urandom_range(1, 5);
    int w;
    for (int p = 0; p < np; p++) begin
      w = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
      if (p > 0) for (int r = 0; r < 5; r++) rs[r] = {rs[r], " "};
      for (int c = 0; c < w; c++) begin
        for (int r = 0; r < 4; r++)
          rs[r] = {rs[r], ($urandom_range(0, 3) == 0) ? " " : $sformatf("%0d", $urandom_range(1, 9))};
        rs[4] = {rs[4], (c != 0) ? " " : ($urandom_range(0, 1) != 0) ? "*" : "+"};
      end
    end
    for (int r = 0; r < 5; r++) begin
      if ($urandom_range(0, 1) != 0)
        while (rs[r].len() > 0 && rs[r][rs[r].len()-1] == ASCII_SP)
          rs[r] = rs[r].substr(0, rs[r].len() - 2);
      txt = {txt, rs[r], crlf ? "\r\n" : "\n"};
    end
    return txt;
  endfunction

  task automatic test_random();
    string txt;
    for (int n = 0; n < 10; n++) begin
      txt = gen_puzzle($urandom_range(0, 1) != 0);
      model(txt);
      do_reset();
      send_text(txt, $urandom_range(0, 2), 0, -1);
      wait_done();
      vectors++;
      if (got.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: %0d required %0d", n, got.size(), exp_q.size());
      end
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_rec%0d: %h required %h", n, i, got[i], exp_q[i]); end
      end
      vectors++;
      if (bus.num_problems !== 11'(exp_q.size())) begin
        errors++; $display("FAIL rand%0d_num: %0d required %0d", n, bus.num_problems, exp_q.size());
      end
      vectors++;
      if (bus.err !== exp_err) begin errors++; $display("FAIL rand%0d_err: %b required %b", n, bus.err, exp_err); end
    end
  endtask

  initial begin
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    test_reset();
    test_basic();
    test_crlf_gaps();
    test_short_row();
    test_wide_problem();
    test_bad_char();
    test_empty();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
